// File: rtl/fifo_pktgate.sv
// fifo_pktgate: store-and-forward gate that releases FIFO words to an AXI-style stream only for committed packets.
module fifo_pktgate #(
    parameter int BW     = 64,
    parameter int LGPKTS = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_fifo_empty,
    input  logic [BW:0]       i_fifo_data,
    output logic              o_fifo_rd,
    input  logic              i_commit,
    output logic              M_AXIN_VALID,
    input  logic              M_AXIN_READY,
    output logic [BW-1:0]     M_AXIN_DATA,
    output logic              M_AXIN_LAST,
    output logic [LGPKTS:0]   o_pkt_count,
    output logic              o_overflow,
    output logic              o_underrun
);
    localparam logic [LGPKTS:0] FULL = {1'b1, {LGPKTS{1'b0}}};
    logic              valid_q, valid_d;
    logic [BW-1:0]     data_q, data_d;
    logic              last_q, last_d;
    logic [LGPKTS:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              und_q, und_d;
    logic              rd, rd_last, inc;
    always_comb begin
        rd      = !i_reset && count_q != '0 && !i_fifo_empty && (!valid_q || M_AXIN_READY);
        rd_last = rd && i_fifo_data[BW];
        inc     = i_commit && !rd_last;
        valid_d = rd || (valid_q && !M_AXIN_READY);
        data_d  = rd ? i_fifo_data[BW-1:0] : data_q;
        last_d  = rd ? i_fifo_data[BW] : last_q;
        // a commit at full capacity is dropped and only recorded as overflow
        count_d = (inc && count_q != FULL) ? count_q + 1'b1 :
                  (rd_last && !i_commit)   ? count_q - 1'b1 : count_q;
        ovf_d   = ovf_q || (inc && count_q == FULL);
        und_d   = und_q || (count_q != '0 && i_fifo_empty);
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            und_q   <= und_d;
        end
    end
    assign o_fifo_rd    = rd;
    assign M_AXIN_VALID = valid_q;
    assign M_AXIN_DATA  = data_q;
    assign M_AXIN_LAST  = last_q;
    assign o_pkt_count  = count_q;
    assign o_overflow   = ovf_q;
    assign o_underrun   = und_q;
endmodule

// File: tb/tb_fifo_pktgate.sv
// tb_fifo_pktgate: table-driven bench for fifo_pktgate with a behavioural upstream FIFO.
module tb_fifo_pktgate;
    localparam int BW     = 16;
    localparam int LGPKTS = 5;
    logic              clk = 1'b0;
    logic              i_reset = 1'b1;
    logic              i_commit = 1'b0;
    logic              ready = 1'b0;
    logic              wr_en = 1'b0;
    logic [BW:0]       wr_data = '0;
    logic              fifo_empty;
    logic [BW:0]       fifo_data;
    logic              o_fifo_rd;
    logic              valid;
    logic [BW-1:0]     data;
    logic              last;
    logic [LGPKTS:0]   count;
    logic              ovf, und;
    logic [BW:0]       mem [128];
    logic [6:0]        wp = '0, rp = '0;
    int                checks = 0;
    int                errors = 0;

    typedef struct {
        logic            wr;
        logic [BW:0]     wd;
        logic            commit;
        logic            rdy;
        logic            e_rd;
        logic            e_valid;
        logic [BW-1:0]   e_data;
        logic            e_last;
        logic [LGPKTS:0] e_cnt;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    assign fifo_empty = (wp == rp);
    assign fifo_data  = mem[rp];

    always @(posedge clk) begin
        if (i_reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_en) begin
                mem[wp] <= wr_data;
                wp      <= wp + 1'b1;
            end
            if (o_fifo_rd)
                rp <= rp + 1'b1;
        end
    end

    fifo_pktgate #(.BW(BW), .LGPKTS(LGPKTS)) dut (
        .i_clk(clk),
        .i_reset(i_reset),
        .i_fifo_empty(fifo_empty),
        .i_fifo_data(fifo_data),
        .o_fifo_rd(o_fifo_rd),
        .i_commit(i_commit),
        .M_AXIN_VALID(valid),
        .M_AXIN_READY(ready),
        .M_AXIN_DATA(data),
        .M_AXIN_LAST(last),
        .o_pkt_count(count),
        .o_overflow(ovf),
        .o_underrun(und)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic wr, input logic [BW:0] wd, input logic commit,
                                input logic rdy, input logic e_rd, input logic e_valid,
                                input logic [BW-1:0] e_data, input logic e_last,
                                input logic [LGPKTS:0] e_cnt);
        tbl.push_back('{wr, wd, commit, rdy, e_rd, e_valid, e_data, e_last, e_cnt});
    endfunction

    function automatic logic [BW:0] w(input logic l, input logic [BW-1:0] p);
        return {l, p};
    endfunction

    initial begin
        // held packet A,B,C then commit; LAST only on C
        add(1, w(0, 16'h00A1), 0, 1, 0, 0, 0, 0, 0);
        add(1, w(0, 16'h00B2), 0, 1, 0, 0, 0, 0, 0);
        add(1, w(1, 16'h00C3), 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            add(0, '0, 0, 1, 0, 0, 0, 0, 0);
        add(0, '0, 1, 1, 0, 0, 0, 0, 0);
        add(0, '0, 0, 1, 1, 0, 0, 0, 1);
        add(0, '0, 0, 1, 1, 1, 16'h00A1, 0, 1);
        add(0, '0, 0, 1, 1, 1, 16'h00B2, 0, 1);
        add(0, '0, 0, 1, 0, 1, 16'h00C3, 1, 0);
        add(0, '0, 0, 1, 0, 0, 0, 0, 0);
        // two 2-word packets, commit coincident with LAST read, 4-cycle stall
        add(1, w(0, 16'h0D04), 0, 1, 0, 0, 0, 0, 0);
        add(1, w(1, 16'h0E05), 0, 1, 0, 0, 0, 0, 0);
        add(1, w(0, 16'h0F06), 1, 1, 0, 0, 0, 0, 0);
        add(1, w(1, 16'h1007), 0, 1, 1, 0, 0, 0, 1);
        add(0, '0, 1, 1, 1, 1, 16'h0D04, 0, 1);
        for (int i = 0; i < 4; i++)
            add(0, '0, 0, 0, 0, 1, 16'h0E05, 1, 1);
        add(0, '0, 0, 1, 1, 1, 16'h0E05, 1, 1);
        add(0, '0, 0, 1, 1, 1, 16'h0F06, 0, 1);
        add(0, '0, 0, 1, 0, 1, 16'h1007, 1, 0);
        add(0, '0, 0, 1, 0, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        #1;
        chk("rst_valid", 32'(valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_flags", 32'({ovf, und}), 0);

        foreach (tbl[k]) begin
            @(negedge clk);
            wr_en    = tbl[k].wr;
            wr_data  = tbl[k].wd;
            i_commit = tbl[k].commit;
            ready    = tbl[k].rdy;
            #1;
            chk($sformatf("row%0d_rd", k), 32'(o_fifo_rd), 32'(tbl[k].e_rd));
            chk($sformatf("row%0d_valid", k), 32'(valid), 32'(tbl[k].e_valid));
            chk($sformatf("row%0d_count", k), 32'(count), 32'(tbl[k].e_cnt));
            chk($sformatf("row%0d_flags", k), 32'({ovf, und}), 0);
            if (tbl[k].e_valid) begin
                chk($sformatf("row%0d_data", k), 32'(data), 32'(tbl[k].e_data));
                chk($sformatf("row%0d_last", k), 32'(last), 32'(tbl[k].e_last));
            end
        end

        // 33 commits with no data: saturate at 32, overflow on the 33rd
        wr_en = 1'b0;
        ready = 1'b0;
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            i_commit = 1'b1;
            #1;
            if (i == 32) begin
                chk("sat_count_32", 32'(count), 32);
                chk("sat_ovf_pre", 32'(ovf), 0);
            end
        end
        @(negedge clk);
        i_commit = 1'b0;
        #1;
        chk("sat_count_33", 32'(count), 32);
        chk("sat_ovf", 32'(ovf), 1);
        chk("sat_und", 32'(und), 1);

        // stalled beat then reset mid-packet
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = w(1, 16'h1234);
        #1;
        chk("h_rd_empty", 32'(o_fifo_rd), 0);
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        chk("h_rd", 32'(o_fifo_rd), 1);
        @(negedge clk);
        #1;
        chk("h_valid", 32'(valid), 1);
        chk("h_data", 32'(data), 32'h1234);
        chk("h_last", 32'(last), 1);
        chk("h_count", 32'(count), 31);
        chk("h_hold_rd", 32'(o_fifo_rd), 0);
        @(negedge clk);
        i_reset = 1'b1;
        #1;
        chk("r_rd", 32'(o_fifo_rd), 0);
        chk("r_valid_pre", 32'(valid), 1);
        @(negedge clk);
        i_reset = 1'b0;
        #1;
        chk("r_valid", 32'(valid), 0);
        chk("r_count", 32'(count), 0);
        chk("r_data", 32'({last, data}), 0);
        chk("r_flags", 32'({ovf, und}), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
